// File: rtl/instr_issue_sched.sv
// ---------------------------------------------------------------------------
// instr_issue_sched
//   Out-of-order issue scheduler. Holds up to INSTR_QUEUE_SIZE decoded
//   instructions, tracks readiness of their two source operands via tag
//   wakeup broadcasts, and presents one eligible instruction per cycle to EX.
//
// Parameters
//   INSTR_QUEUE_SIZE  number of scheduler slots (power of 2, 2..16)
//   TAG_W             physical-register tag width
//   PAYLOAD_W         opaque decoded-instruction payload width
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   flush                        squash all slots (branch mispredict)
//   alloc_valid / alloc_ready    allocation handshake
//   alloc_src{1,2}_tag/_rdy      source tags and initial readiness
//   alloc_payload                instruction payload
//   wake_valid / wake_tag        result-broadcast wakeup
//   issue_valid / issue_ready    issue handshake to EX
//   issue_payload / issue_slot   selected instruction and its slot index
//   count                        number of occupied slots
//
// Configuration macro
//   ISSUE_AGE_ORDER_EN  defined: oldest eligible slot wins (age matrix)
//                       undefined: lowest-index eligible slot wins
// ---------------------------------------------------------------------------
module instr_issue_sched #(
  parameter int unsigned INSTR_QUEUE_SIZE = 8,
  parameter int unsigned TAG_W            = 6,
  parameter int unsigned PAYLOAD_W        = 64
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic                                alloc_valid,
  output logic                                alloc_ready,
  input  logic [TAG_W-1:0]                    alloc_src1_tag,
  input  logic [TAG_W-1:0]                    alloc_src2_tag,
  input  logic                                alloc_src1_rdy,
  input  logic                                alloc_src2_rdy,
  input  logic [PAYLOAD_W-1:0]                alloc_payload,
  input  logic                                wake_valid,
  input  logic [TAG_W-1:0]                    wake_tag,
  output logic                                issue_valid,
  input  logic                                issue_ready,
  output logic [PAYLOAD_W-1:0]                issue_payload,
  output logic [$clog2(INSTR_QUEUE_SIZE)-1:0] issue_slot,
  output logic [$clog2(INSTR_QUEUE_SIZE):0]   count
);

  localparam int unsigned N  = INSTR_QUEUE_SIZE;
  localparam int unsigned IW = $clog2(INSTR_QUEUE_SIZE);
  localparam int unsigned CW = IW + 1;

  typedef enum logic {
    SEL_OPEN,
    SEL_LOCKED
  } sel_state_e;

  // Slot storage
  logic [N-1:0]         valid_q;
  logic [N-1:0]         src1_rdy_q;
  logic [N-1:0]         src2_rdy_q;
  logic [TAG_W-1:0]     src1_tag_q [N];
  logic [TAG_W-1:0]     src2_tag_q [N];
  logic [PAYLOAD_W-1:0] payload_q  [N];

  sel_state_e           state_q, state_d;
  logic [IW-1:0]        lock_slot_q;
  logic [CW-1:0]        count_q;

  logic [N-1:0]         elig;
  logic [N-1:0]         cand;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;
  logic [IW-1:0]        sel_idx;
  logic [IW-1:0]        free_idx;
  logic                 alloc_xfer;
  logic                 issue_xfer;
  logic                 byp1;
  logic                 byp2;

  assign elig = valid_q & src1_rdy_q & src2_rdy_q;

  // ---------------------------------------------------------------------
  // Selection candidates
  // ---------------------------------------------------------------------
`ifdef ISSUE_AGE_ORDER_EN
  // older_q[j][i] = 1 means slot j was allocated before slot i.
  logic [N-1:0] older_q [N];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int unsigned i = 0; i < N; i++) begin
        older_q[i] <= '0;
      end
    end else if (alloc_xfer) begin
      // The new entry is younger than everything currently held; stale bits
      // for invalid slots are harmless since candidates are masked by valid
      // and rewritten when that slot is next allocated.
      for (int unsigned j = 0; j < N; j++) begin
        older_q[free_idx][j] <= 1'b0;
        if (IW'(j) != free_idx) begin
          older_q[j][free_idx] <= 1'b1;
        end
      end
    end
  end

  // A candidate is an eligible slot with no older eligible slot; at most one.
  always_comb begin
    cand = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand[i] = elig[i];
      for (int unsigned j = 0; j < N; j++) begin
        if (elig[j] && older_q[j][i]) begin
          cand[i] = 1'b0;
        end
      end
    end
  end
`else
  assign cand = elig;
`endif

  // Lowest-index candidate
  always_comb begin
    pick_idx = '0;
    pick_any = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (cand[i] && !pick_any) begin
        pick_idx = IW'(i);
        pick_any = 1'b1;
      end
    end
  end

  // Lowest-index free slot
  always_comb begin : free_sel
    logic found;
    found    = 1'b0;
    free_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!valid_q[i] && !found) begin
        free_idx = IW'(i);
        found    = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Issue selection lock FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    issue_valid = (state_q == SEL_LOCKED) || pick_any;
    sel_idx     = (state_q == SEL_LOCKED) ? lock_slot_q : pick_idx;
    issue_xfer  = issue_valid && issue_ready;
    unique case (state_q)
      SEL_OPEN:   if (issue_valid && !issue_ready) state_d = SEL_LOCKED;
      SEL_LOCKED: if (issue_ready)                 state_d = SEL_OPEN;
      default:                                     state_d = SEL_OPEN;
    endcase
    if (flush) begin
      state_d = SEL_OPEN;
    end
  end

  assign issue_slot    = sel_idx;
  assign issue_payload = payload_q[sel_idx];

  // ---------------------------------------------------------------------
  // Allocation handshake and wakeup bypass
  // ---------------------------------------------------------------------
  assign alloc_ready = (count_q < CW'(N)) && !flush;
  assign alloc_xfer  = alloc_valid && alloc_ready;
  assign byp1        = wake_valid && (wake_tag == alloc_src1_tag);
  assign byp2        = wake_valid && (wake_tag == alloc_src2_tag);
  assign count       = count_q;

  // ---------------------------------------------------------------------
  // Control state: valid bits, lock, occupancy
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      state_q     <= SEL_OPEN;
      lock_slot_q <= '0;
      count_q     <= '0;
    end else if (flush) begin
      valid_q <= '0;
      state_q <= SEL_OPEN;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == SEL_OPEN) begin
        lock_slot_q <= pick_idx;
      end
      // Alloc targets an invalid slot and issue a valid one, so never the same.
      if (issue_xfer) begin
        valid_q[sel_idx] <= 1'b0;
      end
      if (alloc_xfer) begin
        valid_q[free_idx] <= 1'b1;
      end
      unique case ({alloc_xfer, issue_xfer})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Slot data: readiness wakeup and allocation writes
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N; i++) begin
      if (wake_valid && valid_q[i]) begin
        if (src1_tag_q[i] == wake_tag) src1_rdy_q[i] <= 1'b1;
        if (src2_tag_q[i] == wake_tag) src2_rdy_q[i] <= 1'b1;
      end
    end
    if (alloc_xfer) begin
      src1_tag_q[free_idx] <= alloc_src1_tag;
      src2_tag_q[free_idx] <= alloc_src2_tag;
      src1_rdy_q[free_idx] <= alloc_src1_rdy || byp1;
      src2_rdy_q[free_idx] <= alloc_src2_rdy || byp2;
      payload_q[free_idx]  <= alloc_payload;
    end
  end

endmodule

// File: tb/tb_instr_issue_sched.sv
module tb_instr_issue_sched;

  localparam int N  = 8;
  localparam int TW = 6;
  localparam int PW = 64;
  localparam logic [PW-1:0] PL_BASE = 64'hC0DE_0000_0000_0000;

  logic          clk = 1'b0;
  logic          rst, flush;
  logic          alloc_valid, alloc_ready;
  logic [TW-1:0] alloc_src1_tag, alloc_src2_tag;
  logic          alloc_src1_rdy, alloc_src2_rdy;
  logic [PW-1:0] alloc_payload;
  logic          wake_valid;
  logic [TW-1:0] wake_tag;
  logic          issue_valid, issue_ready;
  logic [PW-1:0] issue_payload;
  logic [2:0]    issue_slot;
  logic [3:0]    count;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: expected issue order (slot, payload)
  int unsigned   exp_slot [$];
  logic [PW-1:0] exp_pl   [$];
  int unsigned   es;
  logic [PW-1:0] ep;

  always #5 clk = ~clk;

  instr_issue_sched #(
    .INSTR_QUEUE_SIZE(N),
    .TAG_W(TW),
    .PAYLOAD_W(PW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .alloc_valid(alloc_valid),
    .alloc_ready(alloc_ready),
    .alloc_src1_tag(alloc_src1_tag),
    .alloc_src2_tag(alloc_src2_tag),
    .alloc_src1_rdy(alloc_src1_rdy),
    .alloc_src2_rdy(alloc_src2_rdy),
    .alloc_payload(alloc_payload),
    .wake_valid(wake_valid),
    .wake_tag(wake_tag),
    .issue_valid(issue_valid),
    .issue_ready(issue_ready),
    .issue_payload(issue_payload),
    .issue_slot(issue_slot),
    .count(count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    flush          = 1'b0;
    alloc_valid    = 1'b0;
    alloc_src1_tag = '0;
    alloc_src2_tag = '0;
    alloc_src1_rdy = 1'b0;
    alloc_src2_rdy = 1'b0;
    alloc_payload  = '0;
    wake_valid     = 1'b0;
    wake_tag       = '0;
  endtask

  task automatic drive_alloc(input logic [TW-1:0] t1, input logic r1,
                             input logic [TW-1:0] t2, input logic r2,
                             input logic [PW-1:0] pl);
    alloc_valid    = 1'b1;
    alloc_src1_tag = t1;
    alloc_src1_rdy = r1;
    alloc_src2_tag = t2;
    alloc_src2_rdy = r2;
    alloc_payload  = pl;
  endtask

  task automatic do_reset;
    idle();
    issue_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_slot.delete();
    exp_pl.delete();
  endtask

  task automatic test_reset;
    do_reset();
    #1;
    n_checks++;
    if (count !== 4'd0 || issue_valid !== 1'b0 || alloc_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: count=%0d issue_valid=%b alloc_ready=%b, required 0/0/1",
               count, issue_valid, alloc_ready);
    end
  endtask

  task automatic test_fill_drain;
    do_reset();
    for (int i = 0; i < N; i++) begin
      #1;
      n_checks++;
      if (count !== 4'(i)) begin
        n_fail++;
        $display("FAIL fill_count: got %0d, required %0d", count, i);
      end
      drive_alloc('0, 1'b1, '0, 1'b1, PL_BASE | 64'(i));
      #1;
      n_checks++;
      if (alloc_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL fill_alloc_ready: got %b, required 1 at slot %0d", alloc_ready, i);
      end
      exp_slot.push_back(i);
      exp_pl.push_back(PL_BASE | 64'(i));
      tick();
    end
    idle();
    #1;
    n_checks++;
    if (count !== 4'd8 || alloc_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full: count=%0d alloc_ready=%b, required 8/0", count, alloc_ready);
    end
    // Offer a ninth instruction while full: must not be taken.
    drive_alloc('0, 1'b1, '0, 1'b1, 64'hDEAD);
    tick();
    idle();
    #1;
    n_checks++;
    if (count !== 4'd8) begin
      n_fail++;
      $display("FAIL full_reject: count=%0d, required 8", count);
    end
    issue_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      #1;
      n_checks++;
      if (exp_slot.size() == 0) begin
        n_fail++;
        $display("FAIL drain_issue: issue with empty scoreboard");
      end else begin
        es = exp_slot.pop_front();
        ep = exp_pl.pop_front();
        if (issue_valid !== 1'b1 || issue_slot !== 3'(es) || issue_payload !== ep) begin
          n_fail++;
          $display("FAIL drain_issue: valid=%b slot=%0d payload=%h, required 1/%0d/%h",
                   issue_valid, issue_slot, issue_payload, es, ep);
        end
      end
      tick();
    end
    issue_ready = 1'b0;
    #1;
    n_checks++;
    if (count !== 4'd0 || issue_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drained: count=%0d issue_valid=%b, required 0/0", count, issue_valid);
    end
  endtask

  task automatic test_wakeup;
    do_reset();
    drive_alloc(6'd5, 1'b0, '0, 1'b1, 64'h5555);
    exp_slot.push_back(0);
    exp_pl.push_back(64'h5555);
    tick();
    idle();
    wake_valid = 1'b1;
    wake_tag   = 6'd4;
    #1;
    n_checks++;
    if (issue_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wake_wait: issue_valid=%b, required 0", issue_valid);
    end
    tick();
    wake_tag = 6'd5;
    #1;
    n_checks++;
    if (issue_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wake_wrong_tag_or_early: issue_valid=%b, required 0", issue_valid);
    end
    tick();
    wake_valid = 1'b0;
    #1;
    n_checks++;
    if (exp_slot.size() == 0) begin
      n_fail++;
      $display("FAIL wake_issue: issue with empty scoreboard");
    end else begin
      es = exp_slot.pop_front();
      ep = exp_pl.pop_front();
      if (issue_valid !== 1'b1 || issue_slot !== 3'(es) || issue_payload !== ep) begin
        n_fail++;
        $display("FAIL wake_issue: valid=%b slot=%0d payload=%h, required 1/%0d/%h",
                 issue_valid, issue_slot, issue_payload, es, ep);
      end
    end
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    #1;
    n_checks++;
    if (count !== 4'd0 || issue_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wake_accepted: count=%0d issue_valid=%b, required 0/0", count, issue_valid);
    end
  endtask

  task automatic test_bypass;
    do_reset();
    drive_alloc('0, 1'b1, 6'd9, 1'b0, 64'h9999);
    wake_valid = 1'b1;
    wake_tag   = 6'd9;
    exp_slot.push_back(0);
    exp_pl.push_back(64'h9999);
    #1;
    n_checks++;
    if (issue_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bypass_same_cycle: issue_valid=%b, required 0", issue_valid);
    end
    tick();
    idle();
    #1;
    n_checks++;
    if (exp_slot.size() == 0) begin
      n_fail++;
      $display("FAIL bypass_issue: issue with empty scoreboard");
    end else begin
      es = exp_slot.pop_front();
      ep = exp_pl.pop_front();
      if (issue_valid !== 1'b1 || issue_slot !== 3'(es) || issue_payload !== ep) begin
        n_fail++;
        $display("FAIL bypass_issue: valid=%b slot=%0d payload=%h, required 1/%0d/%h",
                 issue_valid, issue_slot, issue_payload, es, ep);
      end
    end
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    // Different tag on the broadcast: no bypass.
    drive_alloc('0, 1'b1, 6'd10, 1'b0, 64'hAAAA);
    wake_valid = 1'b1;
    wake_tag   = 6'd9;
    tick();
    idle();
    #1;
    n_checks++;
    if (issue_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bypass_tag_mismatch: issue_valid=%b, required 0", issue_valid);
    end
  endtask

  task automatic test_lock;
    do_reset();
    drive_alloc(6'd3, 1'b0, '0, 1'b1, 64'hA0A0);
    tick();
    drive_alloc('0, 1'b1, '0, 1'b1, 64'hB0B0);
    tick();
    idle();
    wake_valid = 1'b1;
    wake_tag   = 6'd3;
    exp_slot.push_back(1);
    exp_pl.push_back(64'hB0B0);
    exp_slot.push_back(0);
    exp_pl.push_back(64'hA0A0);
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++;
      if (issue_valid !== 1'b1 || issue_slot !== 3'd1 || issue_payload !== 64'hB0B0) begin
        n_fail++;
        $display("FAIL lock_hold: cycle %0d valid=%b slot=%0d payload=%h, required 1/1/b0b0",
                 c, issue_valid, issue_slot, issue_payload);
      end
      tick();
      wake_valid = 1'b0;
    end
    issue_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_checks++;
      if (exp_slot.size() == 0) begin
        n_fail++;
        $display("FAIL lock_issue: issue with empty scoreboard");
      end else begin
        es = exp_slot.pop_front();
        ep = exp_pl.pop_front();
        if (issue_valid !== 1'b1 || issue_slot !== 3'(es) || issue_payload !== ep) begin
          n_fail++;
          $display("FAIL lock_issue: valid=%b slot=%0d payload=%h, required 1/%0d/%h",
                   issue_valid, issue_slot, issue_payload, es, ep);
        end
      end
      tick();
    end
    issue_ready = 1'b0;
    #1;
    n_checks++;
    if (count !== 4'd0) begin
      n_fail++;
      $display("FAIL lock_drained: count=%0d, required 0", count);
    end
  endtask

  task automatic test_order;
    do_reset();
    drive_alloc('0, 1'b1, '0, 1'b1, 64'h100);
    tick();
    for (int i = 1; i < 4; i++) begin
      drive_alloc(6'd7, 1'b0, '0, 1'b1, 64'h100 + 64'(i));
      tick();
    end
    idle();
    exp_slot.push_back(0);
    exp_pl.push_back(64'h100);
    issue_ready = 1'b1;
    #1;
    n_checks++;
    if (exp_slot.size() == 0) begin
      n_fail++;
      $display("FAIL order_first: issue with empty scoreboard");
    end else begin
      es = exp_slot.pop_front();
      ep = exp_pl.pop_front();
      if (issue_valid !== 1'b1 || issue_slot !== 3'(es) || issue_payload !== ep) begin
        n_fail++;
        $display("FAIL order_first: valid=%b slot=%0d payload=%h, required 1/%0d/%h",
                 issue_valid, issue_slot, issue_payload, es, ep);
      end
    end
    tick();
    issue_ready = 1'b0;
    drive_alloc(6'd7, 1'b0, '0, 1'b1, 64'h104);
    tick();
    idle();
    wake_valid = 1'b1;
    wake_tag   = 6'd7;
    #1;
    n_checks++;
    if (issue_valid !== 1'b0 || count !== 4'd4) begin
      n_fail++;
      $display("FAIL order_waiting: issue_valid=%b count=%0d, required 0/4", issue_valid, count);
    end
    tick();
    wake_valid  = 1'b0;
    issue_ready = 1'b1;
`ifdef ISSUE_AGE_ORDER_EN
    for (int i = 1; i < 4; i++) begin
      exp_slot.push_back(i);
      exp_pl.push_back(64'h100 + 64'(i));
    end
    exp_slot.push_back(0);
    exp_pl.push_back(64'h104);
`else
    exp_slot.push_back(0);
    exp_pl.push_back(64'h104);
    for (int i = 1; i < 4; i++) begin
      exp_slot.push_back(i);
      exp_pl.push_back(64'h100 + 64'(i));
    end
`endif
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++;
      if (exp_slot.size() == 0) begin
        n_fail++;
        $display("FAIL order_issue: issue with empty scoreboard");
      end else begin
        es = exp_slot.pop_front();
        ep = exp_pl.pop_front();
        if (issue_valid !== 1'b1 || issue_slot !== 3'(es) || issue_payload !== ep) begin
          n_fail++;
          $display("FAIL order_issue: step %0d valid=%b slot=%0d payload=%h, required 1/%0d/%h",
                   k, issue_valid, issue_slot, issue_payload, es, ep);
        end
      end
      tick();
    end
    issue_ready = 1'b0;
    #1;
    n_checks++;
    if (count !== 4'd0 || issue_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL order_drained: count=%0d issue_valid=%b, required 0/0", count, issue_valid);
    end
  endtask

  task automatic test_flush;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_alloc('0, 1'b1, '0, 1'b1, 64'h700 + 64'(i));
      tick();
    end
    idle();
    #1;
    n_checks++;
    if (count !== 4'd5) begin
      n_fail++;
      $display("FAIL flush_pre: count=%0d, required 5", count);
    end
    flush = 1'b1;
    drive_alloc('0, 1'b1, '0, 1'b1, 64'hF1F1);
    issue_ready = 1'b1;
    #1;
    n_checks++;
    if (alloc_ready !== 1'b0 || issue_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_cycle: alloc_ready=%b issue_valid=%b, required 0/1",
               alloc_ready, issue_valid);
    end
    tick();
    idle();
    issue_ready = 1'b0;
    #1;
    n_checks++;
    if (count !== 4'd0 || issue_valid !== 1'b0 || alloc_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_after: count=%0d issue_valid=%b alloc_ready=%b, required 0/0/1",
               count, issue_valid, alloc_ready);
    end
    drive_alloc('0, 1'b1, '0, 1'b1, 64'hF2F2);
    exp_slot.push_back(0);
    exp_pl.push_back(64'hF2F2);
    tick();
    idle();
    #1;
    n_checks++;
    if (exp_slot.size() == 0) begin
      n_fail++;
      $display("FAIL flush_realloc: issue with empty scoreboard");
    end else begin
      es = exp_slot.pop_front();
      ep = exp_pl.pop_front();
      if (issue_valid !== 1'b1 || issue_slot !== 3'(es) || issue_payload !== ep
          || count !== 4'd1) begin
        n_fail++;
        $display("FAIL flush_realloc: valid=%b slot=%0d payload=%h count=%0d, required 1/%0d/%h/1",
                 issue_valid, issue_slot, issue_payload, count, es, ep);
      end
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    drive_alloc('0, 1'b1, '0, 1'b1, 64'hE0E0);
    tick();
    drive_alloc('0, 1'b1, '0, 1'b1, 64'hE1E1);
    tick();
    idle();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (count !== 4'd0 || issue_valid !== 1'b0 || alloc_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid: count=%0d issue_valid=%b alloc_ready=%b, required 0/0/1",
               count, issue_valid, alloc_ready);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle();
    issue_ready = 1'b0;
    rst = 1'b1;
    test_reset();
    test_fill_drain();
    test_wakeup();
    test_bypass();
    test_lock();
    test_order();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
